// File: rtl/phase_rotation_gate.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | phase_rotation_gate: 3-stage R(theta) gate, beta *= (cos + i*sin).        |
// | Macro PHASE_ROT_SAT_EN: saturating narrow (default wraps). Rev 1.0        |
// +--------------------------------------------------------------------------+
module phase_rotation_gate #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] alpha_r,
  input  logic signed [WIDTH-1:0] alpha_i,
  input  logic signed [WIDTH-1:0] beta_r,
  input  logic signed [WIDTH-1:0] beta_i,
  input  logic signed [WIDTH-1:0] cos_t,
  input  logic signed [WIDTH-1:0] sin_t,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] new_alpha_r,
  output logic signed [WIDTH-1:0] new_alpha_i,
  output logic signed [WIDTH-1:0] new_beta_r,
  output logic signed [WIDTH-1:0] new_beta_i
);

  localparam int c_pw = 2 * WIDTH;
  localparam int c_sw = 2 * WIDTH + 1;
  localparam logic signed [c_sw-1:0] c_round =
    {{(c_sw - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};

  logic w_adv;
  assign w_adv    = !(out_valid && !out_ready);
  assign in_ready = w_adv;

  logic signed [c_pw-1:0] w_br_x, w_bi_x, w_c_x, w_s_x;
  assign w_br_x = {{WIDTH{beta_r[WIDTH-1]}}, beta_r};
  assign w_bi_x = {{WIDTH{beta_i[WIDTH-1]}}, beta_i};
  assign w_c_x  = {{WIDTH{cos_t[WIDTH-1]}}, cos_t};
  assign w_s_x  = {{WIDTH{sin_t[WIDTH-1]}}, sin_t};

  logic                    r_s1_valid;
  logic signed [c_pw-1:0]  r_p_brc, r_p_bis, r_p_brs, r_p_bic;
  logic signed [WIDTH-1:0] r_s1_ar, r_s1_ai;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_p_brc    <= '0;
      r_p_bis    <= '0;
      r_p_brs    <= '0;
      r_p_bic    <= '0;
      r_s1_ar    <= '0;
      r_s1_ai    <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_p_brc    <= w_br_x * w_c_x;
      r_p_bis    <= w_bi_x * w_s_x;
      r_p_brs    <= w_br_x * w_s_x;
      r_p_bic    <= w_bi_x * w_c_x;
      r_s1_ar    <= alpha_r;
      r_s1_ai    <= alpha_i;
    end
  end

  logic                    r_s2_valid;
  logic signed [c_sw-1:0]  r_s2_re, r_s2_im;
  logic signed [WIDTH-1:0] r_s2_ar, r_s2_ai;

  // One extra bit absorbs the sum of two full-scale products.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_re    <= '0;
      r_s2_im    <= '0;
      r_s2_ar    <= '0;
      r_s2_ai    <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_re    <= {r_p_brc[c_pw-1], r_p_brc} - {r_p_bis[c_pw-1], r_p_bis} + c_round;
      r_s2_im    <= {r_p_brs[c_pw-1], r_p_brs} + {r_p_bic[c_pw-1], r_p_bic} + c_round;
      r_s2_ar    <= r_s1_ar;
      r_s2_ai    <= r_s1_ai;
    end
  end

  logic signed [c_sw-1:0]  w_re_sh, w_im_sh;
  logic signed [WIDTH-1:0] w_re_nar, w_im_nar;
  assign w_re_sh = r_s2_re >>> FRAC;
  assign w_im_sh = r_s2_im >>> FRAC;

`ifdef PHASE_ROT_SAT_EN
  localparam logic signed [c_sw-1:0] c_sat_max = {{(c_sw - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [c_sw-1:0] c_sat_min = {{(c_sw - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  always_comb begin
    w_re_nar = w_re_sh[WIDTH-1:0];
    w_im_nar = w_im_sh[WIDTH-1:0];
    if (w_re_sh > c_sat_max)      w_re_nar = c_sat_max[WIDTH-1:0];
    else if (w_re_sh < c_sat_min) w_re_nar = c_sat_min[WIDTH-1:0];
    if (w_im_sh > c_sat_max)      w_im_nar = c_sat_max[WIDTH-1:0];
    else if (w_im_sh < c_sat_min) w_im_nar = c_sat_min[WIDTH-1:0];
  end
`else
  logic w_unused_msbs;
  assign w_re_nar      = w_re_sh[WIDTH-1:0];
  assign w_im_nar      = w_im_sh[WIDTH-1:0];
  assign w_unused_msbs = ^{w_re_sh[c_sw-1:WIDTH], w_im_sh[c_sw-1:WIDTH]};
`endif

  // Output data only updates on a valid slot so bubbles keep the last sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      new_alpha_r <= '0;
      new_alpha_i <= '0;
      new_beta_r  <= '0;
      new_beta_i  <= '0;
    end else if (w_adv) begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        new_alpha_r <= r_s2_ar;
        new_alpha_i <= r_s2_ai;
        new_beta_r  <= w_re_nar;
        new_beta_i  <= w_im_nar;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_rotation_gate.sv
`default_nettype none
// Directed self-checking bench for phase_rotation_gate (WIDTH=16, FRAC=8).
module tb_phase_rotation_gate;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [15:0] alpha_r, alpha_i, beta_r, beta_i, cos_t, sin_t;
  logic signed [15:0] new_alpha_r, new_alpha_i, new_beta_r, new_beta_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  phase_rotation_gate #(.WIDTH(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alpha_r(alpha_r), .alpha_i(alpha_i),
    .beta_r(beta_r), .beta_i(beta_i),
    .cos_t(cos_t), .sin_t(sin_t),
    .out_valid(out_valid), .out_ready(out_ready),
    .new_alpha_r(new_alpha_r), .new_alpha_i(new_alpha_i),
    .new_beta_r(new_beta_r), .new_beta_i(new_beta_i)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int ar, input int ai, input int br,
                       input int bi, input int c, input int s);
    in_valid = v;
    alpha_r  = 16'(ar);
    alpha_i  = 16'(ai);
    beta_r   = 16'(br);
    beta_i   = 16'(bi);
    cos_t    = 16'(c);
    sin_t    = 16'(s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k_in, k_out, hold;
    logic started, acc;

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_beta_r", new_beta_r, 0);
    check("rst_alpha_i", new_alpha_i, 0);

    // Identity rotation
    drive(1'b1, 100, -50, 300, -7, 256, 0);
    step();
    in_valid = 1'b0;
    step();
    check("id_lat2_valid", out_valid, 0);
    step();
    check("id_valid", out_valid, 1);
    check("id_alpha_r", new_alpha_r, 100);
    check("id_alpha_i", new_alpha_i, -50);
    check("id_beta_r", new_beta_r, 300);
    check("id_beta_i", new_beta_i, -7);
    step();
    check("bubble_valid", out_valid, 0);
    check("bubble_hold", new_beta_r, 300);

    // 90 degrees, back to back
    drive(1'b1, 7, 8, 256, 0, 0, 256);
    step();
    drive(1'b1, 9, 10, 0, 256, 0, 256);
    step();
    in_valid = 1'b0;
    step();
    check("r90a_valid", out_valid, 1);
    check("r90a_beta_r", new_beta_r, 0);
    check("r90a_beta_i", new_beta_i, 256);
    check("r90a_alpha_r", new_alpha_r, 7);
    step();
    check("r90b_valid", out_valid, 1);
    check("r90b_beta_r", new_beta_r, -256);
    check("r90b_beta_i", new_beta_i, 0);
    check("r90b_alpha_i", new_alpha_i, 10);
    step();

    // Rounding half toward +inf
    drive(1'b1, 1, 2, 1, -1, 128, 0);
    step();
    in_valid = 1'b0;
    step();
    step();
    check("rnd_valid", out_valid, 1);
    check("rnd_beta_r", new_beta_r, 1);
    check("rnd_beta_i", new_beta_i, 0);

    // Overflow on imaginary part; alpha extremes pass bit-exact
    drive(1'b1, -32768, 32767, 32767, 32767, 181, 181);
    step();
    in_valid = 1'b0;
    step();
    step();
    check("ovf_valid", out_valid, 1);
    check("ovf_beta_r", new_beta_r, 0);
`ifdef PHASE_ROT_SAT_EN
    check("ovf_beta_i", new_beta_i, 32767);
`else
    check("ovf_beta_i", new_beta_i, -19201);
`endif
    check("ovf_alpha_r", new_alpha_r, -32768);
    check("ovf_alpha_i", new_alpha_i, 32767);
    step();

    // Backpressure: 5 samples, 4-cycle hold once output appears
    k_in = 1;
    k_out = 1;
    hold = 0;
    started = 1'b0;
    for (int cyc = 0; cyc < 40 && k_out <= 5; cyc++) begin
      if (out_valid && !started) begin
        started = 1'b1;
        hold = 4;
      end
      out_ready = (hold == 0);
      if (k_in <= 5) drive(1'b1, k_in, 2 * k_in, 10 * k_in, -k_in, 256, 0);
      else in_valid = 1'b0;
      #1;
      if (hold > 0) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_frozen_beta_r", new_beta_r, 10 * k_out);
        check("bp_frozen_alpha_i", new_alpha_i, 2 * k_out);
        hold--;
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check("bp_beta_r", new_beta_r, 10 * k_out);
        check("bp_beta_i", new_beta_i, -k_out);
        check("bp_alpha_r", new_alpha_r, k_out);
        k_out++;
      end
      step();
      if (acc) k_in++;
    end
    check("bp_count", k_out, 6);
    out_ready = 1'b1;
    in_valid = 1'b0;
    step();
    check("bp_no_dup", out_valid, 0);

    // Reset with samples in flight
    drive(1'b1, 11, 12, 20, 30, 256, 0);
    step();
    drive(1'b1, 13, 14, 40, 50, 256, 0);
    step();
    drive(1'b1, 15, 16, 60, 70, 256, 0);
    step();
    check("mid_a_valid", out_valid, 1);
    check("mid_a_beta_r", new_beta_r, 20);
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_beta_r", new_beta_r, 0);
    check("mid_rst_beta_i", new_beta_i, 0);
    check("mid_rst_alpha_r", new_alpha_r, 0);
    check("mid_rst_alpha_i", new_alpha_i, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_no_stale", out_valid, 0);
    end
    drive(1'b1, 21, 22, 80, 90, 256, 0);
    step();
    in_valid = 1'b0;
    step();
    check("post_lat2_valid", out_valid, 0);
    step();
    check("post_valid", out_valid, 1);
    check("post_beta_r", new_beta_r, 80);
    check("post_beta_i", new_beta_i, 90);
    check("post_alpha_r", new_alpha_r, 21);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
